// File: rtl/board_uart_tx_if.sv
// rtl/board_uart_tx_if.sv - game-state snapshot request and UART line bundle
interface board_uart_tx_if;
    logic [319:0] board;
    logic [20:0]  score;
    logic         send;
    logic         busy;
    logic         done;
    logic         tx;

    modport master (output board, score, send, input busy, done, tx);
    modport slave  (input board, score, send, output busy, done, tx);
endinterface

// File: rtl/board_uart_tx.sv
// rtl/board_uart_tx.sv - 53-byte 8N1 frame of board tiles and score with XOR checksum
module board_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int TILE_W       = 20
) (
    input logic            clk,
    input logic            rst,
    board_uart_tx_if.slave bus
);
    localparam int             BW          = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0]  BAUD_LAST   = BW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]  BAUD_PENULT = BW'(CLKS_PER_BIT - 2);
    localparam logic [5:0]     LAST_BYTE   = 6'd52;
    localparam logic [7:0]     SYNC        = 8'hA5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [5:0]      byte_idx;
    logic [2:0]      bit_idx;
    logic [BW-1:0]   baud;
    logic [7:0]      shreg;
    logic [7:0]      csum;
    logic [319:0]    board_q;
    logic [20:0]     score_q;
    logic            tx_q;
    logic            busy_q;
    logic            done_q;

    logic [8*53-1:0] payload;
    logic [5:0]      next_idx;
    logic [7:0]      next_byte;
    logic            bit_end;

    // Byte 52 slot stays zero; the checksum register is loaded in its place.
    always_comb begin
        payload = '0;
        payload[7:0] = SYNC;
        for (int k = 0; k < 16; k++) begin
            payload[(1 + 3*k)*8 +: 8] = {4'h0, board_q[TILE_W*k + 16 +: 4]};
            payload[(2 + 3*k)*8 +: 8] = board_q[TILE_W*k + 8 +: 8];
            payload[(3 + 3*k)*8 +: 8] = board_q[TILE_W*k +: 8];
        end
        payload[49*8 +: 8] = {3'b000, score_q[20:16]};
        payload[50*8 +: 8] = score_q[15:8];
        payload[51*8 +: 8] = score_q[7:0];
    end

    assign next_idx  = byte_idx + 6'd1;
    assign next_byte = payload[int'(next_idx)*8 +: 8];
    assign bit_end   = (baud == BAUD_LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            byte_idx <= '0;
            bit_idx  <= '0;
            baud     <= '0;
            shreg    <= '0;
            csum     <= '0;
            board_q  <= '0;
            score_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (state != IDLE) begin
                baud <= bit_end ? '0 : baud + 1'b1;
            end
            case (state)
                IDLE: begin
                    if (bus.send) begin
                        board_q  <= bus.board;
                        score_q  <= bus.score;
                        state    <= START;
                        tx_q     <= 1'b0;
                        busy_q   <= 1'b1;
                        byte_idx <= '0;
                        bit_idx  <= '0;
                        baud     <= '0;
                        shreg    <= SYNC;
                        csum     <= SYNC;
                    end
                end
                START: begin
                    if (bit_end) begin
                        state   <= DATA;
                        bit_idx <= '0;
                        tx_q    <= shreg[0];
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx_q  <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx_q    <= shreg[bit_idx + 3'd1];
                        end
                    end
                end
                STOP: begin
                    if (byte_idx == LAST_BYTE) begin
                        // done must land in the last stop-bit cycle, so it is set one cycle early.
                        if (baud == BAUD_PENULT) begin
                            done_q <= 1'b1;
                        end
                        if (bit_end) begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end else if (bit_end) begin
                        state    <= START;
                        tx_q     <= 1'b0;
                        byte_idx <= next_idx;
                        if (next_idx == LAST_BYTE) begin
                            shreg <= csum;
                        end else begin
                            shreg <= next_byte;
                            csum  <= csum ^ next_byte;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.tx   = tx_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
endmodule

// File: tb/tb_board_uart_tx.sv
// tb/tb_board_uart_tx.sv - directed frame decode checks for board_uart_tx
module tb_board_uart_tx;
    localparam int CPB = 4;
    localparam int F   = 53 * 10 * CPB;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    board_uart_tx_if bus ();

    board_uart_tx #(.CLKS_PER_BIT(CPB), .TILE_W(20)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_bytes  [53];
    logic [7:0] exp_bytes [53];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void build_exp(input logic [319:0] b, input logic [20:0] s);
        logic [19:0] t;
        logic [7:0]  x;
        exp_bytes[0] = 8'hA5;
        for (int k = 0; k < 16; k++) begin
            t = b[20*k +: 20];
            exp_bytes[1 + 3*k] = {4'h0, t[19:16]};
            exp_bytes[2 + 3*k] = t[15:8];
            exp_bytes[3 + 3*k] = t[7:0];
        end
        exp_bytes[49] = {3'b000, s[20:16]};
        exp_bytes[50] = s[15:8];
        exp_bytes[51] = s[7:0];
        x = 8'h00;
        for (int i = 0; i < 52; i++) x = x ^ exp_bytes[i];
        exp_bytes[52] = x;
    endfunction

    // Called mid-cycle; send is sampled at the next edge (edge T), returns in cycle T+1.
    task automatic send_pulse();
        bus.send = 1'b1;
        @(posedge clk);
        #1;
        bus.send = 1'b0;
    endtask

    task automatic run_frame(input string name, input bit scramble);
        int busy_err;
        int done_err;
        int frame_err;
        busy_err  = 0;
        done_err  = 0;
        frame_err = 0;
        check({name, "_start_tx"}, {31'd0, bus.tx}, 32'd0);
        for (int c = 1; c <= F; c++) begin
            int bi;
            int ph;
            int by;
            int bt;
            bi = (c - 1) / CPB;
            ph = (c - 1) % CPB;
            by = bi / 10;
            bt = bi % 10;
            if (bus.busy !== 1'b1) busy_err++;
            if (bus.done !== (c == F)) done_err++;
            if (ph == CPB / 2) begin
                if (bt == 0) begin
                    if (bus.tx !== 1'b0) frame_err++;
                end else if (bt == 9) begin
                    if (bus.tx !== 1'b1) frame_err++;
                end else begin
                    rx_bytes[by][bt - 1] = bus.tx;
                end
            end
            if (scramble) begin
                bus.board = {10{$urandom}};
                bus.score = 21'($urandom);
                if (c == 10 || c == F) bus.send = 1'b1;
            end
            @(posedge clk);
            #1;
            bus.send = 1'b0;
        end
        check({name, "_busy_err"}, busy_err, 0);
        check({name, "_done_err"}, done_err, 0);
        check({name, "_framing_err"}, frame_err, 0);
        check({name, "_busy_after"}, {31'd0, bus.busy}, 32'd0);
        check({name, "_done_after"}, {31'd0, bus.done}, 32'd0);
        check({name, "_tx_after"}, {31'd0, bus.tx}, 32'd1);
        for (int i = 0; i < 53; i++) begin
            check($sformatf("%s_byte%0d", name, i), {24'd0, rx_bytes[i]}, {24'd0, exp_bytes[i]});
        end
    endtask

    initial begin
        int err;
        bus.send  = 1'b0;
        bus.board = '0;
        bus.score = '0;
        rst       = 1'b0;

        err = 0;
        for (int i = 0; i < 20; i++) begin
            bus.send  = 1'($urandom);
            bus.board = {10{$urandom}};
            step(1);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.done !== 1'b0) err++;
        end
        check("reset_hold", err, 0);
        bus.send = 1'b0;
        rst      = 1'b1;
        err      = 0;
        for (int i = 0; i < 50; i++) begin
            step(1);
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) err++;
        end
        check("idle_after_reset", err, 0);

        bus.board = '0;
        bus.score = '0;
        build_exp(bus.board, bus.score);
        send_pulse();
        run_frame("zero", 1'b0);
        check("zero_csum_hand", {24'd0, rx_bytes[52]}, 32'hA5);

        bus.board           = '0;
        bus.board[19:0]     = 20'h00800;
        bus.board[319:300]  = 20'hFFFFF;
        bus.score           = 21'h1FFFFF;
        build_exp(bus.board, bus.score);
        send_pulse();
        run_frame("data", 1'b0);
        check("data_b1_3",   {8'd0, rx_bytes[1],  rx_bytes[2],  rx_bytes[3]},  32'h000800);
        check("data_b46_48", {8'd0, rx_bytes[46], rx_bytes[47], rx_bytes[48]}, 32'h0FFFFF);
        check("data_b49_51", {8'd0, rx_bytes[49], rx_bytes[50], rx_bytes[51]}, 32'h1FFFFF);
        check("data_csum_hand", {24'd0, rx_bytes[52]}, 32'hBD);

        bus.board = {10{32'h5A3C_96E1}};
        bus.score = 21'h12345;
        build_exp(bus.board, bus.score);
        send_pulse();
        run_frame("snap", 1'b1);
        err = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus.tx !== 1'b1 || bus.busy !== 1'b0) err++;
            step(1);
        end
        check("snap_no_second_frame", err, 0);

        bus.board = {10{32'h0123_4567}};
        bus.score = 21'h0ABCDE;
        build_exp(bus.board, bus.score);
        send_pulse();
        run_frame("b2b_1", 1'b0);
        bus.board = {10{32'hFEDC_BA98}};
        bus.score = 21'h100001;
        build_exp(bus.board, bus.score);
        send_pulse();
        run_frame("b2b_2", 1'b0);

        bus.board = {10{32'hDEAD_BEEF}};
        bus.score = 21'h0F0F0;
        send_pulse();
        step(699);
        rst = 1'b0;
        #1;
        check("midrst_tx",   {31'd0, bus.tx},   32'd1);
        check("midrst_busy", {31'd0, bus.busy}, 32'd0);
        err = 0;
        for (int i = 0; i < 5; i++) begin
            step(1);
            if (bus.done !== 1'b0 || bus.tx !== 1'b1 || bus.busy !== 1'b0) err++;
        end
        check("midrst_hold", err, 0);
        rst = 1'b1;
        step(5);
        bus.board = {10{32'h1357_9BDF}};
        bus.score = 21'h02468;
        build_exp(bus.board, bus.score);
        send_pulse();
        run_frame("after_rst", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/board_uart_tx.md
# board_uart_tx

Serialises the game state for display on the host over a UART line. It sits downstream of `gameController` and takes its 320-bit `board` and 21-bit `score`. On a one-cycle `send` request it snapshots both and transmits a fixed 53-byte frame as 8N1 UART. A checksum byte closes each frame.

## Interface
Parameters:
- CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range ≥ 2
- TILE_W, 20, bits per tile in `board`; fixed at 20 for this frame format

Ports:
- clk  input  1  system clock; all logic on rising edge
- rst  input  1  asynchronous, active-low reset
- board  input  320  16 tiles × 20 bits; tile k = board[20k+19:20k], tile 0 at LSBs
- score  input  21  current score, unsigned
- send  input  1  frame request; acted on only when `busy` = 0
- busy  output  1  high from the cycle after an accepted `send` until the frame completes
- done  output  1  one-cycle pulse in the final cycle of a frame
- tx  output  1  UART line; idle high

## Operation
- Frame byte order (index 0..52):
  - byte 0: sync 0xA5
  - bytes 1..48: tiles 0..15, 3 bytes each, MSB first; each 20-bit tile is zero-extended to 24 bits
  - bytes 49..51: score zero-extended to 24 bits, MSB first
  - byte 52: checksum = XOR of bytes 0..51, sync byte included
- Snapshot:
  - `board` and `score` are registered in the cycle where `send`=1 and `busy`=0.
  - Later input changes do not affect the frame in flight.
- Checksum accumulates as each byte is loaded. It is cleared on frame accept.
- Each byte is sent 8N1, LSB first:
  - one start bit (0)
  - 8 data bits
  - one stop bit (1)
- Every bit lasts exactly CLKS_PER_BIT cycles, timed by a baud counter 0..CLKS_PER_BIT-1.
- There is no idle gap between bytes: the stop bit of byte n is followed directly by the start bit of byte n+1.
- State machine:
  - IDLE→START on accepted `send`
  - START→DATA after 1 bit time
  - DATA→STOP after 8 bit times
  - STOP→START after 1 bit time if byte index < 52
  - STOP→IDLE after 1 bit time if byte index = 52
- Counters:
  - byte index: 6 bits, 0..52
  - bit index: 3 bits, 0..7
  - baud counter: $clog2(CLKS_PER_BIT) bits
- `send` while `busy`=1 is ignored. It is not queued.
- Reset (asynchronous, any time, including mid-frame):
  - outputs go to tx=1, busy=0, done=0
  - state returns to IDLE
  - all counters, the snapshot and the checksum are cleared
  - a partial frame is abandoned, with no completion of the current byte

## Timing
- `send` sampled high at edge T with busy=0:
  - tx=0 (start bit of byte 0) and busy=1 from cycle T+1
- Frame length F = 53 × 10 × CLKS_PER_BIT cycles.
  - busy is high for cycles T+1 .. T+F.
  - done=1 only in cycle T+F, the last stop-bit cycle.
  - busy=0 from T+F+1.
- A `send` at T+F+1 is accepted, so frames can run back-to-back with a one-cycle idle-high gap.
- A `send` at T+F is ignored because busy is still 1.
- tx is driven from a register, so it is glitch-free.
- Throughput is not pipelined: one frame in flight at most.

## Test plan
All scenarios use CLKS_PER_BIT=4, giving F=2120.
- Reset: hold rst=0 with random `send`/`board` inputs -> tx=1, busy=0, done=0 throughout; release, 50 idle cycles -> tx stays 1.
- All-zero frame: board=0, score=0, `send` pulse at T -> a UART monitor decodes 0xA5, 51×0x00, then 0xA5; busy high T+1..T+2120; done only at T+2120.
- Data frame: tile0=20'h00800, tile15=20'hFFFFF, score=21'h1FFFFF, other tiles 0 ->
  - bytes 1..3 = 00 08 00
  - bytes 46..48 = 0F FF FF
  - bytes 49..51 = 1F FF FF
  - checksum = 0xA5^0x08^0x0F^0xFF^0xFF^0x1F^0xFF^0xFF = 0xBD
- Snapshot and ignore: after `send`, change `board` every cycle and pulse `send` at T+10 and T+2120 -> exactly one frame, carrying the data captured at T; no second frame starts.
- Back-to-back: `send` at T, then at T+2121 -> the second start bit appears at T+2122; both frames decode correctly.
- Reset mid-frame: assert rst at T+700 (inside byte 17) -> tx=1 and busy=0 immediately, with no done pulse; after release, a new `send` produces a complete, correct frame starting at sync byte 0xA5.
